// File: rtl/mem_io_responder_if.sv
// Datapath-to-responder memory bus: read/write strobes, address, write data and
// read data returned one cycle after MemRead.
interface mem_io_responder_if;
  localparam int unsigned DW = 8;

  logic          MemRead;
  logic          wren;
  logic [DW-1:0] address;
  logic [DW-1:0] data;
  logic [DW-1:0] q;

  modport master (output MemRead, wren, address, data, input q);
  modport slave  (input MemRead, wren, address, data, output q);
endinterface

// File: rtl/mem_io_responder.sv
// Memory-bus responder: addresses below IO_BASE pass through to external RAM,
// the I/O window holds LED, synchronized switches, a compare timer and a TX byte FIFO.
module mem_io_responder #(
  parameter logic [7:0]  IO_BASE    = 8'hF0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  mem_io_responder_if.slave bus,
  output logic [7:0]        ram_address,
  output logic              ram_wren,
  output logic [7:0]        ram_data,
  input  logic [7:0]        ram_q,
  input  logic [7:0]        sw_in,
  output logic [7:0]        led_out,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              timer_irq
);
  localparam int unsigned DW = 8;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [DW-1:0] OFF_LED    = 8'd0;
  localparam logic [DW-1:0] OFF_SW     = 8'd1;
  localparam logic [DW-1:0] OFF_TCOUNT = 8'd2;
  localparam logic [DW-1:0] OFF_TCTRL  = 8'd3;
  localparam logic [DW-1:0] OFF_TCMP   = 8'd4;
  localparam logic [DW-1:0] OFF_STATUS = 8'd5;
  localparam logic [DW-1:0] OFF_TXDATA = 8'd6;
  localparam logic [DW-1:0] OFF_TXSTAT = 8'd7;

  logic          w_io_sel;
  logic [DW-1:0] w_off;
  logic          w_io_wr;
  logic [DW-1:0] w_io_rd;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_push_ok;
  logic          w_ovf;
  logic          w_match;
  logic          w_tclr;
  logic [1:0]    w_w1c;

  logic [DW-1:0] r_led;
  logic [DW-1:0] r_sw_meta;
  logic [DW-1:0] r_sw_sync;
  logic [DW-1:0] r_tcount;
  logic [DW-1:0] r_tcmp;
  logic          r_tctrl_en;
  logic [1:0]    r_status;
  logic [DW-1:0] r_io_rdata;
  logic          r_sel_ram;
  logic          r_rd_valid;
  logic [DW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  assign w_io_sel  = (bus.address >= IO_BASE);
  assign w_off     = bus.address - IO_BASE;
  assign w_io_wr   = bus.wren & w_io_sel;
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = ~w_empty & tx_ready;
  assign w_push    = w_io_wr & (w_off == OFF_TXDATA);
  // a full FIFO still accepts a push when the head leaves on the same edge
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_ovf     = w_push & w_full & ~w_pop;
  assign w_match   = r_tctrl_en & (r_tcount == r_tcmp);
  assign w_tclr    = w_io_wr & (w_off == OFF_TCTRL) & bus.data[1];
  assign w_w1c     = (w_io_wr && (w_off == OFF_STATUS)) ? bus.data[1:0] : 2'b00;

  // register read mux, sampled before any same-edge update
  always_comb begin
    w_io_rd = '0;
    if (w_io_sel) begin
      case (w_off)
        OFF_LED:    w_io_rd = r_led;
        OFF_SW:     w_io_rd = r_sw_sync;
        OFF_TCOUNT: w_io_rd = r_tcount;
        OFF_TCTRL:  w_io_rd = DW'(r_tctrl_en);
        OFF_TCMP:   w_io_rd = r_tcmp;
        OFF_STATUS: w_io_rd = DW'(r_status);
        OFF_TXSTAT: w_io_rd = {4'(r_count), 2'b00, w_full, w_empty};
        default:    w_io_rd = '0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_led      <= '0;
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
      r_tcount   <= '0;
      r_tcmp     <= 8'hFF;
      r_tctrl_en <= 1'b0;
      r_status   <= '0;
      r_io_rdata <= '0;
      r_sel_ram  <= 1'b1;
      r_rd_valid <= 1'b0;
    end else begin
      if (bus.MemRead) begin
        r_rd_valid <= 1'b1;
        r_sel_ram  <= ~w_io_sel;
        r_io_rdata <= w_io_rd;
      end
      if (w_io_wr && (w_off == OFF_LED))   r_led      <= bus.data;
      if (w_io_wr && (w_off == OFF_TCMP))  r_tcmp     <= bus.data;
      if (w_io_wr && (w_off == OFF_TCTRL)) r_tctrl_en <= bus.data[0];
      r_sw_meta <= sw_in;
      r_sw_sync <= r_sw_meta;
      if (w_tclr)          r_tcount <= '0;
      else if (r_tctrl_en) r_tcount <= r_tcount + 8'd1;
      // sticky flags: a fresh set wins over a same-edge write-one-to-clear
      r_status <= {w_ovf, w_match} | (r_status & ~w_w1c);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PW'(1);
      if (w_pop)     r_rptr <= r_rptr + PW'(1);
      if (w_push_ok && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push_ok && w_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wptr] <= bus.data;
  end

  assign ram_address = bus.address;
  assign ram_data    = bus.data;
  assign ram_wren    = bus.wren & ~w_io_sel;
  assign led_out     = r_led;
  assign tx_valid    = ~w_empty;
  assign tx_data     = w_empty ? '0 : r_mem[r_rptr];
  assign timer_irq   = r_status[0];
  // until the first read after reset, q shows the cleared io_rdata
  assign bus.q       = (r_rd_valid && r_sel_ram) ? ram_q : r_io_rdata;
endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed vector table, multi-cycle sequences and
// random traffic, all checked against a queue-based behavioural model.
module tb_mem_io_responder;
  localparam logic [7:0]  IO_BASE    = 8'hF0;
  localparam int unsigned FIFO_DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] ram_address, ram_data, ram_q, sw_in, led_out, tx_data;
  logic       ram_wren, tx_valid, tx_ready, timer_irq;

  mem_io_responder_if bus();

  mem_io_responder #(.IO_BASE(IO_BASE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data), .ram_q(ram_q),
    .sw_in(sw_in), .led_out(led_out), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .timer_irq(timer_irq)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model state
  logic [7:0] m_led, m_tcount, m_tcmp, m_sw_old, m_sw_new, m_io_q;
  bit         m_en, m_match, m_ovf, m_rd_seen, m_rd_ram;
  logic [7:0] m_fifo [$];

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_q;
    logic [7:0] exp_led;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_led = 8'h00; m_tcount = 8'h00; m_tcmp = 8'hFF; m_sw_old = 8'h00; m_sw_new = 8'h00;
    m_io_q = 8'h00; m_en = 0; m_match = 0; m_ovf = 0; m_rd_seen = 0; m_rd_ram = 1;
    m_fifo.delete();
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a);
    int n;
    n = m_fifo.size();
    if (a < IO_BASE) return 8'h00;
    case (a - IO_BASE)
      8'd0: return m_led;
      8'd1: return m_sw_old;
      8'd2: return m_tcount;
      8'd3: return {7'b0, m_en};
      8'd4: return m_tcmp;
      8'd5: return {6'b0, m_ovf, m_match};
      8'd7: return {4'(n), 2'b00, n == FIFO_DEPTH, n == 0};
      default: return 8'h00;
    endcase
  endfunction

  // apply one clock edge worth of behaviour to the model, using pre-edge state
  task automatic m_edge(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    logic [7:0] rv, off;
    bit io, iow, pop, push, mset, oset;
    rv   = m_read(a);
    io   = (a >= IO_BASE);
    off  = a - IO_BASE;
    iow  = wr && io;
    pop  = (m_fifo.size() != 0) && tx_ready;
    push = iow && (off == 8'd6);
    mset = m_en && (m_tcount == m_tcmp);
    oset = 0;
    if (pop) void'(m_fifo.pop_front());
    if (push) begin
      if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(d);
      else oset = 1;
    end
    if (iow && off == 8'd3 && d[1]) m_tcount = 8'h00;
    else if (m_en) m_tcount = m_tcount + 8'd1;
    if (iow && off == 8'd3) m_en = d[0];
    if (iow && off == 8'd0) m_led = d;
    if (iow && off == 8'd4) m_tcmp = d;
    m_match = mset || (m_match && !(iow && off == 8'd5 && d[0]));
    m_ovf   = oset || (m_ovf && !(iow && off == 8'd5 && d[1]));
    if (rd) begin
      m_rd_seen = 1; m_rd_ram = !io; m_io_q = rv;
    end
    m_sw_old = m_sw_new;
    m_sw_new = sw_in;
  endtask

  task automatic check_outputs();
    logic [7:0] eq, etx;
    eq  = (m_rd_seen && m_rd_ram) ? ram_q : m_io_q;
    etx = (m_fifo.size() != 0) ? m_fifo[0] : 8'h00;
    chk("q", bus.q, eq);
    chk("led_out", led_out, m_led);
    chk("tx_valid", 8'(tx_valid), 8'(m_fifo.size() != 0));
    chk("tx_data", tx_data, etx);
    chk("timer_irq", 8'(timer_irq), 8'(m_match));
  endtask

  // one bus cycle: drive, check RAM pass-through, clock, check registered outputs
  task automatic step(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    bus.MemRead = rd; bus.wren = wr; bus.address = a; bus.data = d;
    #1;
    chk("ram_wren", 8'(ram_wren), 8'(wr && (a < IO_BASE)));
    chk("ram_address", ram_address, a);
    chk("ram_data", ram_data, d);
    m_edge(rd, wr, a, d);
    @(posedge clock); #1;
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    logic [7:0] exp_seq [4];

    tbl[0]  = '{1'b0, 1'b1, 8'hF0, 8'h5A, 8'h00, 8'h5A};
    tbl[1]  = '{1'b1, 1'b0, 8'hF0, 8'h00, 8'h5A, 8'h5A};
    tbl[2]  = '{1'b1, 1'b0, 8'hF1, 8'h00, 8'h3C, 8'h5A};
    tbl[3]  = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h77, 8'h5A};
    tbl[4]  = '{1'b0, 1'b1, 8'hF6, 8'h11, 8'h77, 8'h5A};
    tbl[5]  = '{1'b0, 1'b1, 8'hF6, 8'h22, 8'h77, 8'h5A};
    tbl[6]  = '{1'b0, 1'b1, 8'hF6, 8'h33, 8'h77, 8'h5A};
    tbl[7]  = '{1'b0, 1'b1, 8'hF6, 8'h44, 8'h77, 8'h5A};
    tbl[8]  = '{1'b0, 1'b1, 8'hF6, 8'h55, 8'h77, 8'h5A};
    tbl[9]  = '{1'b1, 1'b0, 8'hF7, 8'h00, 8'h42, 8'h5A};
    tbl[10] = '{1'b1, 1'b0, 8'hF5, 8'h00, 8'h02, 8'h5A};
    tbl[11] = '{1'b0, 1'b1, 8'hF0, 8'h01, 8'h02, 8'h01};
    tbl[12] = '{1'b1, 1'b1, 8'hF0, 8'h02, 8'h01, 8'h02};
    tbl[13] = '{1'b1, 1'b0, 8'hF0, 8'h00, 8'h02, 8'h02};
    tbl[14] = '{1'b1, 1'b0, 8'hF4, 8'h00, 8'hFF, 8'h02};
    tbl[15] = '{1'b1, 1'b0, 8'hF3, 8'h00, 8'h00, 8'h02};
    tbl[16] = '{1'b0, 1'b1, 8'hFF, 8'hAA, 8'h00, 8'h02};
    tbl[17] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h02};
    tbl[18] = '{1'b1, 1'b0, 8'hF6, 8'h00, 8'h00, 8'h02};
    tbl[19] = '{1'b1, 1'b0, 8'hF2, 8'h00, 8'h00, 8'h02};
    tbl[20] = '{1'b0, 1'b1, 8'h10, 8'h99, 8'h00, 8'h02};

    reset = 1'b1;
    bus.MemRead = 1'b0; bus.wren = 1'b0; bus.address = 8'h00; bus.data = 8'h00;
    ram_q = 8'h77; sw_in = 8'h3C; tx_ready = 1'b0;
    m_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check_outputs();

    // directed vector table
    foreach (tbl[i]) begin
      step(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data);
      chk($sformatf("tbl%0d_q", i), bus.q, tbl[i].exp_q);
      chk($sformatf("tbl%0d_led", i), led_out, tbl[i].exp_led);
    end

    // drain the four bytes kept while the fifth overflowed
    exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain1_valid", 8'(tx_valid), 8'h01);
      chk("drain1_data", tx_data, exp_seq[i]);
      idle();
    end
    chk("drain1_empty", 8'(tx_valid), 8'h00);

    // push into a full FIFO on the same edge as a pop
    tx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 8'hF6, 8'hA0 + 8'(i));
    tx_ready = 1'b1;
    step(1'b0, 1'b1, 8'hF6, 8'h66);
    tx_ready = 1'b0;
    step(1'b1, 1'b0, 8'hF7, 8'h00);
    chk("full_pop_txstat", bus.q, 8'h42);
    exp_seq = '{8'hA2, 8'hA3, 8'hA4, 8'h66};
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain2_data", tx_data, exp_seq[i]);
      idle();
    end
    chk("drain2_empty", 8'(tx_valid), 8'h00);
    tx_ready = 1'b0;

    // timer compare, sticky match, clear, wrap
    step(1'b0, 1'b1, 8'hF4, 8'h05);
    step(1'b0, 1'b1, 8'hF3, 8'h01);
    repeat (5) idle();
    chk("irq_before_match", 8'(timer_irq), 8'h00);
    idle();
    chk("irq_at_match", 8'(timer_irq), 8'h01);
    repeat (3) idle();
    chk("irq_sticky", 8'(timer_irq), 8'h01);
    step(1'b0, 1'b1, 8'hF5, 8'h01);
    chk("irq_w1c", 8'(timer_irq), 8'h00);
    step(1'b0, 1'b1, 8'hF3, 8'h03);
    step(1'b1, 1'b0, 8'hF2, 8'h00);
    chk("tcount_cleared", bus.q, 8'h00);
    repeat (253) idle();
    step(1'b1, 1'b0, 8'hF2, 8'h00);
    chk("tcount_fe", bus.q, 8'hFE);
    step(1'b1, 1'b0, 8'hF2, 8'h00);
    chk("tcount_ff", bus.q, 8'hFF);
    step(1'b1, 1'b0, 8'hF2, 8'h00);
    chk("tcount_wrap", bus.q, 8'h00);
    step(1'b0, 1'b1, 8'hF5, 8'h01);
    chk("irq_clear_again", 8'(timer_irq), 8'h00);
    repeat (3) idle();
    step(1'b0, 1'b1, 8'hF5, 8'h01);
    chk("irq_set_beats_clear", 8'(timer_irq), 8'h01);

    // asynchronous reset with FIFO data, running timer and a read in flight
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 8'hF6, 8'hB0 + 8'(i));
    step(1'b0, 1'b1, 8'hF0, 8'hC3);
    step(1'b1, 1'b0, 8'hF0, 8'h00);
    chk("pre_reset_q", bus.q, 8'hC3);
    bus.MemRead = 1'b1; bus.address = 8'hF4;
    #2 reset = 1'b1;
    #1;
    m_reset();
    check_outputs();
    chk("rst_tx_valid", 8'(tx_valid), 8'h00);
    chk("rst_q", bus.q, 8'h00);
    @(posedge clock); #1;
    reset = 1'b0;
    check_outputs();
    step(1'b1, 1'b0, 8'hF4, 8'h00);
    chk("rst_tcmp", bus.q, 8'hFF);
    step(1'b1, 1'b0, 8'hF2, 8'h00);
    step(1'b1, 1'b0, 8'hF2, 8'h00);
    chk("rst_timer_stopped", bus.q, 8'h00);
    step(1'b1, 1'b0, 8'hF7, 8'h00);
    chk("rst_txstat", bus.q, 8'h01);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (IO_BASE + 8'($urandom_range(0, 15)));
      tx_ready = 1'($urandom);
      sw_in    = 8'($urandom);
      ram_q    = 8'($urandom);
      step(1'($urandom), $urandom_range(0, 2) == 0, a, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Responder side of the processor memory bus: accepts MemRead/wren/address/data from the multicycle datapath and returns q with the same one-cycle read latency as the existing synchronous memory.
- Decodes the 8-bit address space:
  - Below IO_BASE: forwarded to the external RAM port.
  - IO_BASE..0xFF: served by internal peripheral registers (LED register, synchronized switches, free-running timer with compare, output byte FIFO).
- Sits between the datapath and the memory block at the board top level.

Parameters:
IO_BASE, 8'hF0, first address of the I/O window; all lower addresses go to RAM
FIFO_DEPTH, 4, output FIFO entries (power of two, 2..8)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous active-high reset
MemRead  in  1  read strobe from datapath
wren  in  1  write strobe from datapath
address  in  8  bus address
data  in  8  write data
q  out  8  read data, valid the cycle after MemRead
ram_address  out  8  = address (combinational)
ram_wren  out  1  = wren & (address < IO_BASE)
ram_data  out  8  = data
ram_q  in  8  external RAM read data (1-cycle latency)
sw_in  in  8  raw board switches (asynchronous)
led_out  out  8  LED register
tx_data  out  8  FIFO head byte
tx_valid  out  1  FIFO non-empty
tx_ready  in  1  consumer accepts head when tx_valid & tx_ready
timer_irq  out  1  = status[0]

Behaviour:
- Register map (offset from IO_BASE):
  - +0: LED, RW.
  - +1: SW, RO, two-flop synchronized sw_in.
  - +2: TCOUNT, RO.
  - +3: TCTRL, RW. bit0 enable; bit1 clear, self-clearing and reads 0.
  - +4: TCMP, RW.
  - +5: STATUS, RW1C. bit0 match (sticky), bit1 FIFO overflow (sticky).
  - +6: TXDATA, WO; push on write, reads 0.
  - +7: TXSTAT, RO. [7:4] count, bit1 full, bit0 empty.
  - +8..0xFF: unmapped; reads 0, writes ignored.
- Read path:
  - On an edge with MemRead=1, latch region select and, for I/O, the selected register value into io_rdata.
  - q = ram_q when the latched region is RAM, else io_rdata.
  - q holds when MemRead=0.
  - Returned value is the register contents before any same-edge update.
- Write path: I/O writes take effect on the edge with wren=1 and the address in the I/O window. RAM writes only drive ram_wren.
- MemRead and wren both high: the write side effect occurs; the read returns the pre-write value.
- Timer:
  - When TCTRL.enable=1, TCOUNT increments each cycle and wraps 0xFF->0x00.
  - A TCTRL write with bit1=1 zeroes TCOUNT on that edge; clear beats increment.
  - match sets when enable=1 and TCOUNT==TCMP.
  - Set beats a same-cycle W1C clear.
- FIFO:
  - Circular buffer with read/write pointers and count (0..FIFO_DEPTH).
  - Push on TXDATA write; pop on tx_valid & tx_ready.
  - tx_data = head entry and is 0 when empty; tx_valid = count!=0.
  - Push while full and no same-cycle pop: data dropped, overflow sets, count unchanged.
  - Simultaneous push and pop when full: both succeed, count stays FIFO_DEPTH.
  - Simultaneous push and pop when empty: push only, count becomes 1.
- Reset values (asynchronous, any cycle including mid-transfer):
  - q=0, io_rdata=0, region=RAM.
  - LED=0, sync flops=0.
  - TCOUNT=0, TCTRL=0, TCMP=8'hFF, STATUS=0.
  - FIFO pointers and count=0, so tx_valid=0 and tx_data=0.
  - An in-flight read returns 0.

Test Plan:
- Write 0x5A to 0xF0 then MemRead 0xF0 -> led_out=0x5A from next edge; q=0x5A one cycle after MemRead.
- sw_in=0x3C asynchronously, MemRead 0xF1 three cycles later -> q=0x3C; MemRead 0x10 with ram_q=0x77 -> q=0x77 the cycle after, ram_wren=0 throughout.
- TCMP=0x05, TCTRL=0x01 -> TCOUNT reaches 5 after 5 enabled cycles, timer_irq=1 and stays; write 0x01 to 0xF5 with TCOUNT!=5 -> timer_irq=0; TCTRL=0x03 -> TCOUNT=0 next cycle; run to 0xFF -> wraps to 0x00.
- tx_ready=0, push 0x11,0x22,0x33,0x44,0x55 -> TXSTAT=0x42 (count 4, full), STATUS bit1=1, 0x55 dropped; raise tx_ready -> tx_data sequence 0x11,0x22,0x33,0x44, then tx_valid=0.
- FIFO full, push 0x66 in same cycle as pop -> count stays 4 and 0x66 later emerges last; MemRead+wren together on 0xF0 (old 0x01, new 0x02) -> q=0x01, led_out=0x02.
- Assert reset mid-sequence with FIFO holding 3 bytes, timer running, and a read pending -> all outputs at reset values on the same cycle; tx_valid=0, q=0, TCMP reads 0xFF.
